// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: combinational grant with bounded hold,
// combinational address/data mux, and per-requester registered read return.
module dmem_arbiter #(
  parameter int HOLD_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] a0,
  input  logic [31:0] wd0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rd0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] a1,
  input  logic [31:0] wd1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rd1,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  logic       owner;
  logic [3:0] hold_cnt;

  // Lone requester always wins; on a tie the owner keeps the port until its
  // hold budget is spent, then the other side gets it.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && !req1) begin
        gnt0 = 1'b1;
      end else if (req1 && !req0) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (hold_cnt < HOLD_LIM) begin
          gnt0 = ~owner;
          gnt1 = owner;
        end else begin
          gnt0 = owner;
          gnt1 = ~owner;
        end
      end
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_a  = 32'h0;
    mem_wd = 32'h0;
    if (gnt0) begin
      mem_we = we0;
      mem_a  = a0;
      mem_wd = wd0;
    end else if (gnt1) begin
      mem_we = we1;
      mem_a  = a1;
      mem_wd = wd1;
    end
  end

  // owner resets to requester 0 so the first contested grant after reset
  // goes to requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= 1'b0;
      hold_cnt <= 4'd0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rd0      <= 32'h0;
      rd1      <= 32'h0;
    end else begin
      if (gnt0 || gnt1) begin
        if (gnt1 == owner) begin
          hold_cnt <= (hold_cnt == 4'd15) ? 4'd15 : hold_cnt + 4'd1;
        end else begin
          owner    <= gnt1;
          hold_cnt <= 4'd1;
        end
      end else begin
        hold_cnt <= 4'd0;
      end
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0 && !we0) rd0 <= mem_rd;
      if (gnt1 && !we1) rd1 <= mem_rd;
    end
  end

endmodule
